// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, imported by the
// receiver top and its synchronizer.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;
  localparam int DATA_BITS   = 8;

  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BITPOS_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx pin; all stages reset
// to the idle (high) line level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic system_clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receive stage with sticky ready/overrun status.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking (8N1 otherwise).
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       rx_tick,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       rx_busy
);

  import uart_pkg::*;

  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [SAMPLE_W-1:0]  sample_reg, sample_next;
  logic [BITPOS_W-1:0]  bitpos_reg, bitpos_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic [DATA_BITS-1:0] dout_reg, dout_next;
  logic                 rdy_reg, rdy_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 stop_done;
`ifdef UART_RX_PARITY_EN
  logic                 par_done;
  logic                 parity_err_reg, parity_err_next;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .system_clk(system_clk),
    .reset     (reset),
    .rx        (rx),
    .rx_s      (rx_s)
  );

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state_reg     <= RX_IDLE;
      sample_reg    <= '0;
      bitpos_reg    <= '0;
      shreg_reg     <= '0;
      dout_reg      <= '0;
      rdy_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      sample_reg    <= sample_next;
      bitpos_reg    <= bitpos_next;
      shreg_reg     <= shreg_next;
      dout_reg      <= dout_next;
      rdy_reg       <= rdy_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    sample_next = sample_reg;
    bitpos_next = bitpos_reg;
    shreg_next  = shreg_reg;
    stop_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_done    = 1'b0;
`endif
    if (rx_tick) begin
      case (state_reg)
        RX_IDLE: begin
          if (!rx_s) begin
            state_next  = RX_START;
            sample_next = '0;
          end
        end
        RX_START: begin
          // A start bit that vanishes before mid-bit is treated as line noise.
          if (rx_s) begin
            state_next = RX_IDLE;
          end else if (sample_reg == SAMPLE_W'(MID_SAMPLE)) begin
            state_next  = RX_DATA;
            sample_next = '0;
            bitpos_next = '0;
          end else begin
            sample_next = sample_reg + 1'b1;
          end
        end
        RX_DATA: begin
          sample_next = sample_reg + 1'b1;
          if (sample_reg == SAMPLE_W'(LAST_SAMPLE)) begin
            shreg_next[bitpos_reg] = rx_s;
            if (bitpos_reg == BITPOS_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = RX_PARITY;
`else
              state_next = RX_STOP;
`endif
            end else begin
              bitpos_next = bitpos_reg + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          sample_next = sample_reg + 1'b1;
          if (sample_reg == SAMPLE_W'(LAST_SAMPLE)) begin
            par_done   = 1'b1;
            state_next = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          sample_next = sample_reg + 1'b1;
          if (sample_reg == SAMPLE_W'(LAST_SAMPLE)) begin
            stop_done  = 1'b1;
            state_next = rx_s ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            state_next = RX_IDLE;
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  // A byte completing in the same cycle as rdy_clr is a fresh byte, not an overrun.
  always_comb begin
    dout_next      = dout_reg;
    rdy_next       = rdy_reg;
    frame_err_next = frame_err_reg;
    overrun_next   = overrun_reg;
    if (rdy_clr) begin
      rdy_next     = 1'b0;
      overrun_next = 1'b0;
    end
    if (stop_done) begin
      dout_next      = shreg_reg;
      rdy_next       = 1'b1;
      frame_err_next = ~rx_s;
      if (rdy_reg && !rdy_clr) begin
        overrun_next = 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_comb begin
    parity_err_next = parity_err_reg;
    if (par_done) begin
      parity_err_next = (^shreg_reg) ^ rx_s;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = dout_reg;
  assign rdy       = rdy_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign rx_busy   = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are scheduled as tick-indexed
// events, and a per-cycle compare checks every output against that model.
`timescale 1ns/1ps
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DONE_OFS = PAR_EN ? 168 : 152;

  logic       system_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       rx_tick    = 1'b0;
  logic       rx         = 1'b1;
  logic       rdy_clr    = 1'b0;
  logic [7:0] dout;
  logic       rdy, frame_err, overrun, parity_err, rx_busy;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .rx_tick   (rx_tick),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .dout      (dout),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  initial forever #5 system_clk = ~system_clk;

  // kind: 0 = line goes busy, 1 = line goes idle, 2 = byte completes
  typedef struct {
    int         tick;
    int         kind;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } ev_t;

  typedef struct packed {
    logic [7:0] dout;
    logic       rdy;
    logic       fe;
    logic       ovr;
    logic       pe;
    logic       busy;
  } model_t;

  ev_t    ev_q[$];
  model_t m = '0;
  int     g_tick = 0;
  int     vectors = 0;
  int     fails = 0;

  function automatic model_t model_next(input model_t cur, input logic tk,
                                        input logic clr, input int nt);
    model_t     n;
    logic       done;
    logic [7:0] d;
    logic       fe, pe;
    n = cur; done = 1'b0; d = 8'h00; fe = 1'b0; pe = 1'b0;
    if (tk) begin
      foreach (ev_q[k]) begin
        if (ev_q[k].tick == nt) begin
          case (ev_q[k].kind)
            0: n.busy = 1'b1;
            1: n.busy = 1'b0;
            default: begin
              done = 1'b1; d = ev_q[k].data; fe = ev_q[k].fe; pe = ev_q[k].pe;
            end
          endcase
        end
      end
    end
    if (clr) begin
      n.rdy = 1'b0; n.ovr = 1'b0;
    end
    if (done) begin
      if (cur.rdy && !clr) n.ovr = 1'b1;
      n.rdy = 1'b1; n.dout = d; n.fe = fe; n.pe = pe;
    end
    return n;
  endfunction

  always @(posedge system_clk) begin
    if (!reset) begin
      m <= '0;
    end else begin
      m <= model_next(m, rx_tick, rdy_clr, g_tick + 1);
      if (rx_tick) g_tick <= g_tick + 1;
    end
  end

  task automatic next_cycle();
    @(negedge system_clk);
    vectors++;
    if ({dout, rdy, frame_err, overrun, parity_err, rx_busy} !== m) begin
      fails++;
      $display("FAIL cycle t=%0t tick=%0d: dut dout=%h rdy=%b fe=%b ovr=%b pe=%b busy=%b, model dout=%h rdy=%b fe=%b ovr=%b pe=%b busy=%b",
               $time, g_tick, dout, rdy, frame_err, overrun, parity_err, rx_busy,
               m.dout, m.rdy, m.fe, m.ovr, m.pe, m.busy);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_ev(input int tick, input int kind, input logic [7:0] d,
                        input logic fe, input logic pe);
    ev_t e;
    e.tick = tick; e.kind = kind; e.data = d; e.fe = fe; e.pe = pe;
    ev_q.push_back(e);
  endtask

  // One tick period of four cycles; rx changes right after the previous tick.
  // clr: 0 none, 1 pulse rdy_clr on the tick cycle, 2 pulse on a non-tick cycle.
  task automatic do_tick(input logic rxv, input int clr);
    rx = rxv; rdy_clr = (clr == 2);
    next_cycle(); rdy_clr = 1'b0;
    next_cycle();
    next_cycle();
    rx_tick = 1'b1; rdy_clr = (clr == 1);
    next_cycle();
    rx_tick = 1'b0; rdy_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_tick(1'b1, 0);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0; rx = 1'b1; rx_tick = 1'b0; rdy_clr = 1'b0;
    ev_q.delete();
    repeat (n) next_cycle();
    reset = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                            input int abort_at, input int clr_at);
    logic [10:0] bits;
    int          nbits, t0;
    t0    = g_tick + 1;
    nbits = PAR_EN ? 11 : 10;
    bits  = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    if (PAR_EN) begin
      bits[9]  = (^b) ^ bad_par;
      bits[10] = stop_bit;
    end else begin
      bits[9]  = stop_bit;
    end
    add_ev(t0, 0, 8'h00, 1'b0, 1'b0);
    add_ev(t0 + DONE_OFS, 2, b, ~stop_bit, PAR_EN ? bad_par : 1'b0);
    if (stop_bit) add_ev(t0 + DONE_OFS, 1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < nbits * 16; i++) begin
      if (i == abort_at) return;
      do_tick(bits[i/16], (i == clr_at) ? 1 : 0);
    end
  endtask

  initial begin
    apply_reset(3);
    chk("reset dout", dout, 8'h00);
    chk("reset rdy", {7'b0, rdy}, 8'h00);
    chk("reset busy", {7'b0, rx_busy}, 8'h00);
    chk("reset fe", {7'b0, frame_err}, 8'h00);
    chk("reset ovr", {7'b0, overrun}, 8'h00);
    chk("reset pe", {7'b0, parity_err}, 8'h00);
    idle(5);

    // 0x55, latency pinned at the completion tick
    send_frame(8'h55, 1'b1, 1'b0, DONE_OFS, -1);
    chk("t1 rdy before done", {7'b0, rdy}, 8'h00);
    chk("t1 busy before done", {7'b0, rx_busy}, 8'h01);
    do_tick(1'b1, 0);
    chk("t1 rdy", {7'b0, rdy}, 8'h01);
    chk("t1 dout", dout, 8'h55);
    chk("t1 fe", {7'b0, frame_err}, 8'h00);
    chk("t1 ovr", {7'b0, overrun}, 8'h00);
    chk("t1 busy", {7'b0, rx_busy}, 8'h00);
    idle(7);

    // start-bit glitch of four ticks
    do_tick(1'b1, 2);
    chk("t2 rdy cleared", {7'b0, rdy}, 8'h00);
    add_ev(g_tick + 1, 0, 8'h00, 1'b0, 1'b0);
    add_ev(g_tick + 5, 1, 8'h00, 1'b0, 1'b0);
    repeat (4) do_tick(1'b0, 0);
    chk("t2 busy during glitch", {7'b0, rx_busy}, 8'h01);
    do_tick(1'b1, 0);
    chk("t2 busy after glitch", {7'b0, rx_busy}, 8'h00);
    chk("t2 rdy", {7'b0, rdy}, 8'h00);
    idle(20);

    // framing error followed by a long break
    send_frame(8'hA3, 1'b0, 1'b0, -1, -1);
    repeat (40) do_tick(1'b0, 0);
    chk("t3 busy in break", {7'b0, rx_busy}, 8'h01);
    chk("t3 fe", {7'b0, frame_err}, 8'h01);
    chk("t3 dout", dout, 8'hA3);
    add_ev(g_tick + 1, 1, 8'h00, 1'b0, 1'b0);
    do_tick(1'b1, 0);
    chk("t3 busy after release", {7'b0, rx_busy}, 8'h00);
    idle(40);
    do_tick(1'b1, 2);

    // overrun
    send_frame(8'h12, 1'b1, 1'b0, -1, -1);
    send_frame(8'h34, 1'b1, 1'b0, -1, -1);
    chk("t4 ovr", {7'b0, overrun}, 8'h01);
    chk("t4 dout", dout, 8'h34);
    chk("t4 fe", {7'b0, frame_err}, 8'h00);
    do_tick(1'b1, 2);
    chk("t4 rdy after clr", {7'b0, rdy}, 8'h00);
    chk("t4 ovr after clr", {7'b0, overrun}, 8'h00);

    // rdy_clr coinciding with completion while rdy is already high
    send_frame(8'h66, 1'b1, 1'b0, -1, -1);
    send_frame(8'h7E, 1'b1, 1'b0, -1, DONE_OFS);
    chk("t5 rdy", {7'b0, rdy}, 8'h01);
    chk("t5 ovr", {7'b0, overrun}, 8'h00);
    chk("t5 dout", dout, 8'h7E);

    // reset mid-frame, then a clean frame with deliberately wrong parity
    send_frame(8'hFF, 1'b1, 1'b0, 60, -1);
    chk("t6 busy mid-frame", {7'b0, rx_busy}, 8'h01);
    apply_reset(3);
    chk("t6 reset dout", dout, 8'h00);
    chk("t6 reset rdy", {7'b0, rdy}, 8'h00);
    chk("t6 reset busy", {7'b0, rx_busy}, 8'h00);
    chk("t6 reset ovr", {7'b0, overrun}, 8'h00);
    idle(10);
    send_frame(8'h0F, 1'b1, 1'b1, -1, -1);
    chk("t6 dout", dout, 8'h0F);
    chk("t6 rdy", {7'b0, rdy}, 8'h01);
    chk("t6 fe", {7'b0, frame_err}, 8'h00);
    chk("t6 pe", {7'b0, parity_err}, {7'b0, PAR_EN});
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
